menlo_i2s_tx: RTL
=================

Name: menlo_i2s_tx

Overview:
Parametrised multi-lane I2S transmitter for the HDMI audio path (ADV7513), running on one system clock. It generates sclk and lrclk internally by division and buffers stereo frames in a small FIFO with a valid/ready push interface. It serialises standard I2S, with lrclk leading the MSB by one bit. Additions: selectable built-in test tone, per-lane enable, and underrun detection and counting.

Parameters:
DATA_WIDTH, 16, sample bits per channel (1..SLOT_WIDTH)
SLOT_WIDTH, 16, sclk bits per channel slot; bits below DATA_WIDTH are zero-padded
NUM_LANES, 4, number of I2S data lanes; all carry the same frame
CLK_DIV, 4, clk cycles per sclk period; even, >=2
FIFO_DEPTH, 8, stereo frames buffered; power of two, >=2
TONE_STEPS, 48, entries in the test-tone table (one sine period)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
in_left  in  DATA_WIDTH  left sample, two's complement
in_right  in  DATA_WIDTH  right sample, two's complement
in_valid  in  1  frame offered
in_ready  out  1  FIFO can accept a frame (= not full)
test_mode  in  1  1 = output internal sine tone instead of FIFO data
lane_en  in  NUM_LANES  per-lane output enable
sclk  out  1  I2S bit clock
lrclk  out  1  word select; 0 = left, 1 = right
i2s  out  NUM_LANES  serial data lanes
fifo_level  out  $clog2(FIFO_DEPTH)+1  frames currently buffered
underrun_count  out  16  saturating count of frames with no data

Behaviour:
- Reset values: sclk=0, lrclk=0, i2s=0, fifo_level=0, in_ready=1 (combinational from the empty FIFO), underrun_count=0, tone index=0. The bit position p resets to 2*SLOT_WIDTH-1, so the first sclk falling edge is a frame boundary.
- Reset mid-operation: all state clears immediately and buffered frames are discarded. No partial frame resumes.
- sclk: divider count d runs 0..CLK_DIV-1 and wraps. sclk=0 for d<CLK_DIV/2, else 1. All outputs are registered.
- "Falling edge" means the clk cycle where d wraps to 0. On each falling edge, p advances mod 2*SLOT_WIDTH, and lrclk and i2s update in that same cycle.
- Data at p: for p<SLOT_WIDTH, left slot bit (SLOT_WIDTH-1-p); otherwise right slot bit (2*SLOT_WIDTH-1-p). MSB goes first.
- Slot contents: sample in the top DATA_WIDTH bits, remaining bits 0.
- lrclk=1 exactly for p in [SLOT_WIDTH-1, 2*SLOT_WIDTH-2]. This gives the one-bit I2S lead over the MSB.
- Frame boundary (falling edge with p becoming 0): the next frame is latched and its left MSB is driven in that same cycle. test_mode and lane_en are sampled only here and apply for the whole frame.
- Frame source, test_mode=0:
  - FIFO not empty: pop the head.
  - FIFO empty: underrun. Output a zero frame and increment underrun_count, saturating at 0xFFFF.
- Frame source, test_mode=1:
  - Left = right = tone[idx]; the FIFO is not popped and no underrun is counted.
  - idx increments per frame and wraps TONE_STEPS-1 -> 0.
  - The table is a 16-bit signed sine (peak +32767 at idx 12, -32768 at idx 36, 0 at idx 0 and 24).
  - DATA_WIDTH<16: use the top DATA_WIDTH bits. DATA_WIDTH>16: left-justify and zero-fill.
  - idx holds its value while test_mode=0.
- Lane enable: disabled lane outputs 0. Enabled lanes carry identical data.
- FIFO push: occurs on any clk with in_valid && in_ready and takes effect in the next cycle. Pushes while full are impossible (in_ready=0).
- Simultaneous push and pop:
  - Non-empty FIFO: fifo_level is unchanged.
  - Empty FIFO: the pop is an underrun, and the pushed frame becomes the head for the next boundary.
- fifo_level updates one cycle after the push/pop edge. in_ready = (fifo_level != FIFO_DEPTH).
- Producer latency: a frame pushed into an empty FIFO at least one clk before a boundary goes out at that boundary.

Test Plan:
- Reset, defaults (CLK_DIV=4, SLOT=16, DATA=16) -> sclk period 4 clk; lrclk period 128 clk, falling one sclk before each left MSB; i2s=0; underrun_count increments once per frame.
- Push L=0xA5C3, R=0x0F0F -> lane 0 emits 1010010111000011 then 0000111100001111 MSB-first; lrclk toggles at p=15 and p=31; fifo_level returns to 0.
- Hold in_valid=1 without draining: push 8 frames -> fifo_level=8, in_ready=0; 9th frame not accepted. Frames then emerge in order, one per 128 clk; in_ready rises the cycle after the first pop.
- DATA_WIDTH=12, SLOT_WIDTH=16, push L=0x800 -> slot bits 1000_0000_0000_0000, trailing 4 bits 0.
- test_mode=1 mid-frame -> the current frame completes from its source; the next frame is tone[0]=0, then 4276, 8480, ...; idx wraps after 48 frames; fifo_level unchanged.
- lane_en=4'b0101 -> lanes 1 and 3 held 0, lanes 0 and 2 identical. Assert reset_n low at p=20 -> all outputs 0 immediately, FIFO empty, first boundary on the first sclk falling edge after release.

Source files
------------

// File: rtl/menlo_i2s_tx_if.sv
// Frame push interface for the I2S transmitter:
// stereo sample pair with a valid/ready handshake.
interface menlo_i2s_tx_if #(
   parameter int DATA_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] in_left;
   logic [DATA_WIDTH-1:0] in_right;
   logic                  in_valid;
   logic                  in_ready;

   modport master (
      output in_left, in_right, in_valid,
      input  in_ready
   );

   modport slave (
      input  in_left, in_right, in_valid,
      output in_ready
   );
endinterface

// File: rtl/menlo_i2s_tx.sv
// Multi-lane I2S transmitter: clock division, frame FIFO,
// built-in sine test tone, lane enables, underrun counting.
module menlo_i2s_tx #(
   parameter int DATA_WIDTH = 16,
   parameter int SLOT_WIDTH = 16,
   parameter int NUM_LANES  = 4,
   parameter int CLK_DIV    = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int TONE_STEPS = 48
) (
   input  logic                          clk,
   input  logic                          reset_n,
   menlo_i2s_tx_if.slave                 push,
   input  logic                          test_mode,
   input  logic [NUM_LANES-1:0]          lane_en,
   output logic                          sclk,
   output logic                          lrclk,
   output logic [NUM_LANES-1:0]          i2s,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [15:0]                   underrun_count
);

   localparam int FB   = 2 * SLOT_WIDTH;
   localparam int PW   = $clog2(FB);
   localparam int DW   = $clog2(CLK_DIV);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int LW   = AW + 1;
   localparam int IW   = $clog2(TONE_STEPS);

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
   localparam logic [PW-1:0] P_LAST   = PW'(FB - 1);
   localparam logic [PW-1:0] P_LR_LO  = PW'(SLOT_WIDTH - 1);
   localparam logic [PW-1:0] P_LR_HI  = PW'(FB - 2);
   localparam logic [LW-1:0] L_FULL   = LW'(FIFO_DEPTH);
   localparam logic [IW-1:0] I_LAST   = IW'(TONE_STEPS - 1);

   logic [DW-1:0]           div_q, div_d;
   logic [PW-1:0]           pos_q, pos_d;
   logic [FB-1:0]           frame_q;
   logic [NUM_LANES-1:0]    lane_q;
   logic                    sclk_q, lrclk_q;
   logic [NUM_LANES-1:0]    i2s_q;
   logic [AW-1:0]           wr_q, rd_q;
   logic [LW-1:0]           cnt_q;
   logic [15:0]             urun_q;
   logic [IW-1:0]           idx_q;
   logic [2*DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

   logic                    fall, bound;
   logic                    push_ok, pop, under;
   logic [DATA_WIDTH-1:0]   tone_s, src_l, src_r;
   logic [FB-1:0]           new_frame;

   // First quarter of a 16-bit sine, truncated toward zero.
   function automatic logic [15:0] quarter(input int unsigned k);
      logic [15:0] v;
      v = 16'd0;
      unique case (k)
         0:  v = 16'd0;
         1:  v = 16'd4276;
         2:  v = 16'd8480;
         3:  v = 16'd12539;
         4:  v = 16'd16383;
         5:  v = 16'd19947;
         6:  v = 16'd23169;
         7:  v = 16'd25995;
         8:  v = 16'd28377;
         9:  v = 16'd30272;
         10: v = 16'd31650;
         11: v = 16'd32486;
         12: v = 16'd32767;
         default: v = 16'd0;
      endcase
      return v;
   endfunction

   // Full 48-step period by mirroring; trough pinned to -32768.
   function automatic logic [15:0] tone_f(input logic [IW-1:0] i);
      int unsigned k;
      int unsigned m;
      logic [15:0] v;
      k = 32'(i) % 24;
      m = (k <= 12) ? k : 24 - k;
      v = quarter(m);
      if (32'(i) == 36) v = 16'h8000;
      else if (32'(i) >= 24) v = -v;
      return v;
   endfunction

   // Sample left-justified in its slot, low bits zero.
   function automatic logic [SLOT_WIDTH-1:0] to_slot(
      input logic [DATA_WIDTH-1:0] s
   );
      logic [DATA_WIDTH+SLOT_WIDTH-1:0] w;
      w = {s, {SLOT_WIDTH{1'b0}}};
      return w[DATA_WIDTH+SLOT_WIDTH-1 -: SLOT_WIDTH];
   endfunction

   logic [DATA_WIDTH+15:0] tone_w;

   assign fall    = (div_q == DIV_LAST);
   assign bound   = fall && (pos_q == P_LAST);
   assign push_ok = push.in_valid && push.in_ready;
   assign pop     = bound && !test_mode && (cnt_q != '0);
   assign under   = bound && !test_mode && (cnt_q == '0);
   assign tone_w  = {tone_f(idx_q), {DATA_WIDTH{1'b0}}};
   assign tone_s  = tone_w[DATA_WIDTH+15 -: DATA_WIDTH];

   // Divider and bit-position next state.
   always_comb begin
      div_d = fall ? '0 : div_q + DW'(1);
      pos_d = pos_q;
      if (fall) pos_d = (pos_q == P_LAST) ? '0 : pos_q + PW'(1);
   end

   // Source of the frame latched at the next boundary.
   always_comb begin
      src_l = '0;
      src_r = '0;
      if (test_mode) begin
         src_l = tone_s;
         src_r = tone_s;
      end else if (cnt_q != '0) begin
         {src_l, src_r} = mem_q[rd_q];
      end
      new_frame = {to_slot(src_l), to_slot(src_r)};
   end

   // Serialiser: clocks, frame latch, shift-out, tone index, underruns.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q   <= '0;
         pos_q   <= P_LAST;
         frame_q <= '0;
         lane_q  <= '0;
         sclk_q  <= 1'b0;
         lrclk_q <= 1'b0;
         i2s_q   <= '0;
         urun_q  <= '0;
         idx_q   <= '0;
      end else begin
         div_q  <= div_d;
         sclk_q <= (div_d >= DIV_HALF);
         if (fall) begin
            pos_q   <= pos_d;
            lrclk_q <= (pos_d >= P_LR_LO) && (pos_d <= P_LR_HI);
            if (bound) begin
               frame_q <= new_frame;
               lane_q  <= lane_en;
               i2s_q   <= lane_en & {NUM_LANES{new_frame[FB-1]}};
               if (test_mode)
                  idx_q <= (idx_q == I_LAST) ? '0 : idx_q + IW'(1);
               if (under && urun_q != 16'hFFFF)
                  urun_q <= urun_q + 16'd1;
            end else begin
               frame_q <= frame_q << 1;
               i2s_q   <= lane_q & {NUM_LANES{frame_q[FB-2]}};
            end
         end
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_ok) wr_q <= wr_q + AW'(1);
         if (pop)     rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + LW'(push_ok) - LW'(pop);
      end
   end

   // FIFO storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= {push.in_left, push.in_right};
   end

   assign push.in_ready  = (cnt_q != L_FULL);
   assign sclk           = sclk_q;
   assign lrclk          = lrclk_q;
   assign i2s            = i2s_q;
   assign fifo_level     = cnt_q;
   assign underrun_count = urun_q;

endmodule
